pc_fetch_ctrl: RTL
==================

// Module: pc_fetch_ctrl
// PURPOSE
//  Fetch sequencer for the program counter register: computes next_pc each cycle, fetches over an
//  instruction-memory req/ack handshake, holds the fetched word for decode under stall, and applies
//  branch/jump/exception redirects. Sits between the pc register, imem and the IF/ID stage.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  first fetch address after reset
//  EXC_VECTOR    32'h0000_0180  exception handler address
// PORTS
//  clk            in   1   clock, all state on rising edge
//  reset          in   1   synchronous, active-high reset
//  cur_pc         in   32  current PC from pc register
//  next_pc        out  32  value loaded into pc register every cycle (comb)
//  imem_req       out  1   fetch request, held until imem_ack
//  imem_addr      out  32  fetch address (= cur_pc), stable while imem_req=1
//  imem_ack       in   1   read data valid this cycle
//  imem_rdata     in   32  instruction word
//  stall          in   1   decode cannot accept; hold if_* outputs
//  branch_taken   in   1   branch redirect request
//  branch_target  in   32  branch target
//  jump           in   1   j/jal/jr redirect request
//  jump_target    in   32  jump target
//  exc            in   1   exception redirect request
//  if_valid       out  1   if_instr/if_pc valid for decode
//  if_instr       out  32  fetched instruction
//  if_pc          out  32  address of if_instr
//  epc            out  32  if_pc captured on exc
// BEHAVIOUR
//  - Reset (sync): state=S_RST; if_valid=0, if_instr=0, if_pc=0, epc=0, imem_req=0; next_pc=RESET_VECTOR.
//  - States: S_RST, S_FETCH, S_HOLD, S_DRAIN. S_RST -> S_FETCH after one cycle, next_pc=RESET_VECTOR.
//  - redirect = exc|jump|branch_taken; target priority exc(EXC_VECTOR) > jump > branch. Ignored in S_RST.
//  - Default next_pc = cur_pc (PC held) unless a rule below assigns it.
//  - S_FETCH: imem_req=1. ack & !redirect: if_instr<=imem_rdata, if_pc<=cur_pc, if_valid<=1,
//    next_pc=cur_pc+4, -> S_HOLD. Latency: ack cycle -> if_valid next cycle.
//  - S_FETCH & redirect: next_pc=target; ack same cycle -> data discarded, stay S_FETCH; no ack -> S_DRAIN.
//  - S_DRAIN: imem_req=1, addr unchanged (old request); ack -> discard, -> S_FETCH. Further redirects
//    in S_DRAIN: next_pc=new target (latest wins), stay until ack.
//  - S_HOLD: if_valid=1, imem_req=0. stall -> hold all if_*. !stall -> if_valid<=0, -> S_FETCH.
//    redirect (any stall value) -> if_valid<=0, next_pc=target, -> S_FETCH.
//  - exc: epc<=if_pc same edge (regardless of if_valid); exc alone wins over simultaneous jump/branch.
//  - +4 is modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000. Targets used unmodified (no alignment check).
//  - imem_ack while imem_req=0 is ignored (assertion flags protocol error).
//  - reset mid-fetch: outstanding request dropped; a late ack in S_RST/S_FETCH-first-cycle is
//    not accepted before req is re-issued (bench must not ack in S_RST).
// STRUCTURE
//  - Shared package mips_pkg: state encoding (S_RST/S_FETCH/S_HOLD/S_DRAIN), RESET_VECTOR,
//    EXC_VECTOR defaults, PC_INC=32'd4.
//  - Sub-module pc_redirect_sel: combinational priority select (redirect, target) from exc/jump/branch.
//  - pc register instantiated by parent; this block drives its next_pc, reads cur_pc.
// TESTING
//  1 reset 3 cycles, release, ack every fetch in 1 cycle, no stall -> imem_addr 0,4,8; if_pc 0,4,8.
//  2 stall=1 for 5 cycles in S_HOLD with if_instr=32'h2008_0005 -> if_* and next_pc held; then released.
//  3 branch_taken, target 32'h0000_0040, during S_FETCH without ack, ack 2 cycles later
//    -> acked data discarded (if_valid stays 0), next fetch imem_addr=32'h40.
//  4 exc+jump same cycle in S_HOLD, if_pc=32'h24 -> epc=32'h24, next fetch at 32'h180.
//  5 cur_pc=32'hFFFF_FFFC fetch acked -> next_pc=32'h0000_0000.
//  6 reset asserted mid-S_DRAIN -> all outputs reset values next cycle, first fetch at RESET_VECTOR.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module : mips_pkg
// Brief  : Shared fetch-sequencer types and constants.
// Rev    : 1.0  initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Sequential increment; wraps modulo 2^32 by construction.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_INC;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_ctrl_if
// Brief  : Instruction-memory req/ack fetch bus.
// Rev    : 1.0  initial release
// ============================================================================
interface pc_fetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_sel.sv
`default_nettype none
// ============================================================================
// Module : pc_redirect_sel
// Brief  : Priority select of redirect target: exception > jump > branch.
// Rev    : 1.0  initial release
// ============================================================================
module pc_redirect_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        exc,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [31:0] jump_target,
  input  logic [31:0] branch_target,
  output logic        redirect,
  output logic [31:0] target
);

  always_comb begin
    redirect = exc | jump | branch_taken;
    target   = branch_target;
    if (exc) begin
      target = EXC_VECTOR;
    end else if (jump) begin
      target = jump_target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pc_fetch_ctrl
// Brief  : PC fetch sequencer: next_pc generation, imem handshake, IF/ID hold
//          and branch/jump/exception redirect.
// Rev    : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            cur_pc,
  output logic [31:0]            next_pc,
  pc_fetch_ctrl_if.master        imem,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
  input  logic                   jump,
  input  logic [31:0]            jump_target,
  input  logic                   exc,
  output logic                   if_valid,
  output logic [31:0]            if_instr,
  output logic [31:0]            if_pc,
  output logic [31:0]            epc
);

  fetch_state_t r_state;
  logic         r_imem_req;
  logic [31:0]  r_drain_addr;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_epc;

  logic         w_redirect;
  logic [31:0]  w_target;
  logic         w_ack;

  pc_redirect_sel #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_sel (
    .exc           (exc),
    .jump          (jump),
    .branch_taken  (branch_taken),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .redirect      (w_redirect),
    .target        (w_target)
  );

  // An ack only counts while a request is actually outstanding.
  assign w_ack = r_imem_req & imem.imem_ack;

  // While draining, cur_pc already points at the redirect target, so the
  // abandoned request's address is replayed from a register.
  assign imem.imem_req  = r_imem_req;
  assign imem.imem_addr = (r_state == S_DRAIN) ? r_drain_addr : cur_pc;

  assign if_valid = r_if_valid;
  assign if_instr = r_if_instr;
  assign if_pc    = r_if_pc;
  assign epc      = r_epc;

  always_comb begin
    next_pc = cur_pc;
    if (reset || (r_state == S_RST)) begin
      next_pc = RESET_VECTOR;
    end else if (w_redirect) begin
      next_pc = w_target;
    end else if ((r_state == S_FETCH) && w_ack) begin
      next_pc = pc_plus4(cur_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_RST;
      r_imem_req   <= 1'b0;
      r_drain_addr <= 32'd0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= 32'd0;
      r_if_pc      <= 32'd0;
      r_epc        <= 32'd0;
    end else begin
      if (exc && (r_state != S_RST)) begin
        r_epc <= r_if_pc;
      end
      case (r_state)
        S_RST: begin
          r_state    <= S_FETCH;
          r_imem_req <= 1'b1;
        end
        S_FETCH: begin
          if (w_redirect) begin
            if (!w_ack) begin
              r_state      <= S_DRAIN;
              r_drain_addr <= cur_pc;
            end
          end else if (w_ack) begin
            r_if_instr <= imem.imem_rdata;
            r_if_pc    <= cur_pc;
            r_if_valid <= 1'b1;
            r_imem_req <= 1'b0;
            r_state    <= S_HOLD;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            r_state <= S_FETCH;
          end
        end
        S_HOLD: begin
          if (w_redirect || !stall) begin
            r_if_valid <= 1'b0;
            r_imem_req <= 1'b1;
            r_state    <= S_FETCH;
          end
        end
        default: begin
          r_state    <= S_RST;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  a_ack_needs_req : assert property (@(posedge clk) disable iff (reset)
    imem.imem_ack |-> r_imem_req);

  a_addr_stable : assert property (@(posedge clk) disable iff (reset)
    (r_imem_req && !imem.imem_ack) |=> $stable(imem.imem_addr));

endmodule
`default_nettype wire
